// File: rtl/ens0_layer2_out_stage.sv
// Registered valid/ready boundary between layer-2 activations and layer-3 inputs,
// built as a 2-entry skid buffer. Optional counters enabled by LN_STAGE_STATS_EN.
module ens0_layer2_out_stage #(
  parameter int WIDTH = 512
`ifdef LN_STAGE_STATS_EN
  ,
  parameter int CNT_W = 32
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef LN_STAGE_STATS_EN
  ,
  output logic [CNT_W-1:0] stat_accepted,
  output logic [CNT_W-1:0] stat_stalls
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;
  logic             accept;
  logic             emit;

  assign accept   = in_valid & in_ready;
  assign emit     = out_valid & out_ready;
  assign out_data = main_q;

  // in_ready is a flop of its own, so layer 2 never sees a combinational path from out_ready.
  // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= EMPTY;
      main_q    <= '0;
      skid_q    <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          in_ready <= 1'b1;
          if (accept) begin
            main_q    <= in_data;
            out_valid <= 1'b1;
            state     <= ONE;
          end
        end
        ONE: begin
          case ({accept, emit})
            2'b11: main_q <= in_data;
            2'b10: begin
              skid_q   <= in_data;
              in_ready <= 1'b0;
              state    <= FULL;
            end
            2'b01: begin
              out_valid <= 1'b0;
              state     <= EMPTY;
            end
            default: ;
          endcase
        end
        FULL: begin
          if (emit) begin
            main_q   <= skid_q;
            in_ready <= 1'b1;
            state    <= ONE;
          end
        end
        default: begin
          state     <= EMPTY;
          out_valid <= 1'b0;
          in_ready  <= 1'b0;
        end
      endcase
    end
  end

`ifdef LN_STAGE_STATS_EN
  // Saturating counters: they stick at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_accepted <= '0;
      stat_stalls   <= '0;
    end else begin
      if (accept && (stat_accepted != '1))
        stat_accepted <= stat_accepted + CNT_W'(1);
      if (out_valid && !out_ready && (stat_stalls != '1))
        stat_stalls <= stat_stalls + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_ens0_layer2_out_stage.sv
// Self-checking bench for ens0_layer2_out_stage: directed scenarios plus a
// randomized run scored against a queue-based FIFO model.
module tb_ens0_layer2_out_stage;

  localparam int WIDTH = 512;
`ifdef LN_STAGE_STATS_EN
  localparam int CNT_W = 4;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
`ifdef LN_STAGE_STATS_EN
  logic [CNT_W-1:0] stat_accepted;
  logic [CNT_W-1:0] stat_stalls;
`endif

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

`ifdef LN_STAGE_STATS_EN
  ens0_layer2_out_stage #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .stat_accepted(stat_accepted), .stat_stalls(stat_stalls)
  );
`else
  ens0_layer2_out_stage #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );
`endif

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [WIDTH-1:0] rand_vec();
    logic [WIDTH-1:0] v;
    for (int i = 0; i < WIDTH / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (out_valid !== 1'b0 || out_data !== '0 || in_ready !== 1'b0)
        $display("FAIL reset_state cyc%0d: out_valid=%b in_ready=%b out_data=%h, required 0/0/0",
                 c, out_valid, in_ready, out_data);
      else passes++;
    end
    rst = 1'b0;
    tick();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL reset_release: in_ready=%b out_valid=%b, required 1/0", in_ready, out_valid);
    else passes++;
  endtask

  task automatic test_stream();
    out_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      in_valid = 1'b1;
      in_data  = WIDTH'(k);
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== WIDTH'(k) || in_ready !== 1'b1)
        $display("FAIL stream_k%0d: out_valid=%b in_ready=%b out_data=%0h, required 1/1/%0h",
                 k, out_valid, in_ready, out_data, k);
      else passes++;
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b0)
      $display("FAIL stream_drain: out_valid=%b, required 0", out_valid);
    else passes++;
  endtask

  task automatic test_skid();
    logic [WIDTH-1:0] a, b;
    a = '1;
    b = {(WIDTH/8){8'h5A}};
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = a;
    tick();
    in_data = b;
    tick();
    in_valid = 1'b0; in_data = rand_vec();
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== a)
        $display("FAIL skid_full_hold cyc%0d: in_ready=%b out_valid=%b out_data=%h, required 0/1/A",
                 c, in_ready, out_valid, out_data);
      else passes++;
      tick();
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== b || in_ready !== 1'b1)
      $display("FAIL skid_second: out_valid=%b in_ready=%b out_data=%h, required 1/1/B",
               out_valid, in_ready, out_data);
    else passes++;
    tick();
    checks++;
    if (out_valid !== 1'b0)
      $display("FAIL skid_drain: out_valid=%b, required 0", out_valid);
    else passes++;
  endtask

  task automatic test_reset_full();
    logic [WIDTH-1:0] c_vec;
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = rand_vec();
    tick();
    in_data = rand_vec();
    tick();
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_data !== '0)
      $display("FAIL reset_full: out_valid=%b in_ready=%b out_data=%h, required 0/0/0",
               out_valid, in_ready, out_data);
    else passes++;
    rst = 1'b0;
    out_ready = 1'b1;
    tick();
    c_vec = rand_vec();
    in_valid = 1'b1; in_data = c_vec;
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_data !== c_vec)
      $display("FAIL reset_full_c: out_valid=%b out_data=%h, required 1/%h", out_valid, out_data, c_vec);
    else passes++;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (out_valid !== 1'b0)
        $display("FAIL reset_full_stale cyc%0d: out_valid=%b out_data=%h, required 0",
                 c, out_valid, out_data);
      else passes++;
    end
  endtask

  // Reference: an ideal FIFO of depth 2 that accepts whenever it is not full.
  task automatic test_random();
    logic [WIDTH-1:0] q[$];
    int sent = 0;
    int got = 0;
    int cyc = 0;
    bit acc, emt, bad;
    bad = 1'b0;
    while ((sent < 10000 || q.size() != 0) && cyc < 80000) begin
      in_valid  = (sent < 10000) && ($urandom_range(1) == 1);
      out_ready = ($urandom_range(1) == 1);
      in_data   = rand_vec();
      #1;
      if (!bad) begin
        checks++;
        if (out_valid !== (q.size() != 0) || in_ready !== (q.size() < 2)) begin
          $display("FAIL random_flags cyc%0d: out_valid=%b in_ready=%b, required %b/%b",
                   cyc, out_valid, in_ready, q.size() != 0, q.size() < 2);
          bad = 1'b1;
        end else passes++;
      end
      acc = in_valid && (q.size() < 2);
      emt = out_ready && (q.size() != 0);
      if (emt) begin
        checks++;
        if (out_data !== q[0])
          $display("FAIL random_data vec%0d: got %h required %h", got, out_data, q[0]);
        else passes++;
        void'(q.pop_front());
        got++;
      end
      if (acc) begin
        q.push_back(in_data);
        sent++;
      end
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    checks++;
    if (got !== 10000)
      $display("FAIL random_count: received %0d vectors, required 10000 (cycles %0d)", got, cyc);
    else passes++;
  endtask

`ifdef LN_STAGE_STATS_EN
  task automatic test_stats();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (stat_accepted !== '0 || stat_stalls !== '0)
      $display("FAIL stats_reset: accepted=%0d stalls=%0d, required 0/0", stat_accepted, stat_stalls);
    else passes++;
    out_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      in_valid = 1'b1; in_data = rand_vec();
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b0;
    for (int c = 0; c < 3; c++) tick();
    out_ready = 1'b1;
    tick();
    tick();
    checks++;
    if (stat_accepted !== 4'd15 || stat_stalls !== 4'd3)
      $display("FAIL stats_sat: accepted=%0d stalls=%0d, required 15/3", stat_accepted, stat_stalls);
    else passes++;
  endtask
`endif

  initial begin
    test_reset();
    test_stream();
    test_skid();
    test_reset_full();
    test_random();
`ifdef LN_STAGE_STATS_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
